// File: rtl/ram_phase_scheduler_pkg.sv
// Shared phase encoding, default RAM geometry and write-ownership rule for the
// solver RAM scheduler, IO module and solver core.
package ram_phase_scheduler_pkg;

    localparam int DEF_ADDRESS_WIDTH = 13;
    localparam int DEF_DATA_WIDTH    = 64;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_LOAD  = 3'd1,
        PH_TURN  = 3'd2,
        PH_SOLVE = 3'd3,
        PH_SEND  = 3'd4
    } phase_e;

    // Only the IO module in LOAD and the solver in SOLVE may write the RAM.
    function automatic logic wr_owner_legal(input phase_e ph, input logic solver_owns);
        return ((ph == PH_LOAD) && !solver_owns) || ((ph == PH_SOLVE) && solver_owns);
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Saturating cycle counter with synchronous clear and a terminal-count flag
// that fires once TIMEOUT_CYCLES-1 is reached.
module phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    assign terminal = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !terminal) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ram_phase_scheduler.sv
// Load/solve/send phase FSM and RAM port arbiter between the IO module and the
// solver core, with solve watchdog and protocol-error pulse.
module ram_phase_scheduler
    import ram_phase_scheduler_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start_Load,
    input  logic                     Done_Loading,
    input  logic                     Start_Send,
    input  logic                     Done_Sending,
    input  logic                     Solver_Done,
    input  logic                     IO_WR_Enable,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_WR,
    input  logic [DATA_WIDTH-1:0]    IO_Data_WR,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_RD_A,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_RD_B,
    input  logic                     Solver_WR_Enable,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_WR,
    input  logic [DATA_WIDTH-1:0]    Solver_Data_WR,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_A,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_B,
    output logic                     RAM_WR_Enable,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_WR,
    output logic [DATA_WIDTH-1:0]    RAM_Data_WR,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B,
    output logic                     Solver_Start,
    output logic [2:0]               Phase,
    output logic                     Results_Valid,
    output logic                     Timeout,
    output logic                     Protocol_Error
);

    typedef struct packed {
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] addr_wr;
        logic [DATA_WIDTH-1:0]    data_wr;
        logic [ADDRESS_WIDTH-1:0] addr_rd_a;
        logic [ADDRESS_WIDTH-1:0] addr_rd_b;
    } ram_req_t;

    phase_e   state_q, state_d;
    logic     rv_q, rv_d;
    logic     to_q, to_d;
    logic     err_q, err_d;
    logic     start_q;
    logic     wd_tc;
    ram_req_t io_req, sv_req, ram_req;

    phase_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_phase_watchdog (
        .clk     (CLK),
        .rst_n   (RST),
        .clear   (state_q != PH_SOLVE),
        .enable  (state_q == PH_SOLVE),
        .terminal(wd_tc)
    );

    always_comb begin
        state_d = state_q;
        rv_d    = rv_q;
        to_d    = to_q;
        err_d   = (state_q != PH_IDLE) && (Start_Load || Start_Send);
        unique case (state_q)
            PH_IDLE: begin
                if (Start_Load) begin
                    state_d = PH_LOAD;
                    rv_d    = 1'b0;
                    to_d    = 1'b0;
                    err_d   = Start_Send;
                end else if (Start_Send) begin
                    if (rv_q) state_d = PH_SEND;
                    else      err_d   = 1'b1;
                end
            end
            PH_LOAD:  if (Done_Loading) state_d = PH_TURN;
            PH_TURN:  state_d = PH_SOLVE;
            PH_SOLVE: begin
                // Solver_Done takes priority over an expiring watchdog.
                if (Solver_Done) begin
                    state_d = PH_IDLE;
                    rv_d    = 1'b1;
                end else if (wd_tc) begin
                    state_d = PH_IDLE;
                    to_d    = 1'b1;
                end
            end
            PH_SEND:  if (Done_Sending) state_d = PH_IDLE;
            default:  state_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= PH_IDLE;
            rv_q    <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rv_q    <= rv_d;
            to_q    <= to_d;
            err_q   <= err_d;
            start_q <= (state_q == PH_TURN);
        end
    end

    assign io_req = '{we: IO_WR_Enable, addr_wr: IO_Address_WR, data_wr: IO_Data_WR,
                      addr_rd_a: IO_Address_RD_A, addr_rd_b: IO_Address_RD_B};
    assign sv_req = '{we: Solver_WR_Enable, addr_wr: Solver_Address_WR, data_wr: Solver_Data_WR,
                      addr_rd_a: Solver_Address_RD_A, addr_rd_b: Solver_Address_RD_B};

    // Gating with RST drops an in-flight write the instant reset asserts.
    always_comb begin
        ram_req    = (state_q == PH_SOLVE) ? sv_req : io_req;
        ram_req.we = ram_req.we && RST && wr_owner_legal(state_q, state_q == PH_SOLVE);
    end

    assign RAM_WR_Enable    = ram_req.we;
    assign RAM_Address_WR   = ram_req.addr_wr;
    assign RAM_Data_WR      = ram_req.data_wr;
    assign RAM_Address_RD_A = ram_req.addr_rd_a;
    assign RAM_Address_RD_B = ram_req.addr_rd_b;

    assign Solver_Start   = start_q;
    assign Phase          = state_q;
    assign Results_Valid  = rv_q;
    assign Timeout        = to_q;
    assign Protocol_Error = err_q;

endmodule

// File: tb/tb_ram_phase_scheduler.sv
// Scoreboard bench: stimulus queues expected phase changes and pulse cycles,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_ram_phase_scheduler;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int TO = 12;  // long enough for a 10-cycle solve, short enough to time out

    logic          CLK = 1'b0, RST = 1'b0;
    logic          Start_Load = 0, Done_Loading = 0, Start_Send = 0, Done_Sending = 0, Solver_Done = 0;
    logic          IO_WR_Enable = 0, Solver_WR_Enable = 0;
    logic [AW-1:0] IO_Address_WR = 0, IO_Address_RD_A = 'h11, IO_Address_RD_B = 'h12;
    logic [AW-1:0] Solver_Address_WR = 0, Solver_Address_RD_A = 'h21, Solver_Address_RD_B = 'h22;
    logic [DW-1:0] IO_Data_WR = 0, Solver_Data_WR = 0;
    logic          RAM_WR_Enable, Solver_Start, Results_Valid, Timeout, Protocol_Error;
    logic [AW-1:0] RAM_Address_WR, RAM_Address_RD_A, RAM_Address_RD_B;
    logic [DW-1:0] RAM_Data_WR;
    logic [2:0]    Phase;

    ram_phase_scheduler #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .Start_Load(Start_Load), .Done_Loading(Done_Loading), .Start_Send(Start_Send),
        .Done_Sending(Done_Sending), .Solver_Done(Solver_Done),
        .IO_WR_Enable(IO_WR_Enable), .IO_Address_WR(IO_Address_WR), .IO_Data_WR(IO_Data_WR),
        .IO_Address_RD_A(IO_Address_RD_A), .IO_Address_RD_B(IO_Address_RD_B),
        .Solver_WR_Enable(Solver_WR_Enable), .Solver_Address_WR(Solver_Address_WR),
        .Solver_Data_WR(Solver_Data_WR), .Solver_Address_RD_A(Solver_Address_RD_A),
        .Solver_Address_RD_B(Solver_Address_RD_B),
        .RAM_WR_Enable(RAM_WR_Enable), .RAM_Address_WR(RAM_Address_WR), .RAM_Data_WR(RAM_Data_WR),
        .RAM_Address_RD_A(RAM_Address_RD_A), .RAM_Address_RD_B(RAM_Address_RD_B),
        .Solver_Start(Solver_Start), .Phase(Phase), .Results_Valid(Results_Valid),
        .Timeout(Timeout), .Protocol_Error(Protocol_Error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    int exp_phase[$];
    int exp_err[$];
    int exp_ss[$];
    logic [2:0] prev_phase = 3'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: pulse/change at cycle %0d, expected none", nm, cyc);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Monitor: every observed phase change and pulse must match a queued expectation.
    always @(negedge CLK) begin
        if (Phase != prev_phase) begin
            if (exp_phase.size() == 0) fail("phase_unexpected");
            else chk("phase_seq", 64'(Phase), 64'(exp_phase.pop_front()));
            prev_phase = Phase;
        end
        if (Solver_Start) begin
            if (exp_ss.size() == 0) fail("solver_start_unexpected");
            else chk("solver_start_cycle", 64'(cyc), 64'(exp_ss.pop_front()));
        end
        if (Protocol_Error) begin
            if (exp_err.size() == 0) fail("protocol_error_unexpected");
            else chk("protocol_error_cycle", 64'(cyc), 64'(exp_err.pop_front()));
        end
    end

    task automatic load_to_solve();
        Start_Load = 1; exp_phase.push_back(1); tick(); Start_Load = 0;
        Done_Loading = 1; exp_phase.push_back(2); exp_phase.push_back(3);
        exp_ss.push_back(cyc + 2);
        tick(); Done_Loading = 0;
        tick();
    endtask

    initial begin
        int s;
        // reset: write requests present but nothing may reach the RAM
        IO_WR_Enable = 1; Solver_WR_Enable = 1;
        ticks(2);
        chk("rst_phase", 64'(Phase), 0);
        chk("rst_rv", 64'(Results_Valid), 0);
        chk("rst_timeout", 64'(Timeout), 0);
        chk("rst_perr", 64'(Protocol_Error), 0);
        chk("rst_start", 64'(Solver_Start), 0);
        chk("rst_we", 64'(RAM_WR_Enable), 0);
        RST = 1; IO_WR_Enable = 0; Solver_WR_Enable = 0;
        tick();

        // full run with ownership checks
        Start_Load = 1; exp_phase.push_back(1); tick(); Start_Load = 0;
        IO_WR_Enable = 1; IO_Address_WR = 5; IO_Data_WR = 'hAB;
        Solver_WR_Enable = 1; Solver_Address_WR = 7; Solver_Data_WR = 'h77;
        #2;
        chk("load_we", 64'(RAM_WR_Enable), 1);
        chk("load_addr", 64'(RAM_Address_WR), 5);
        chk("load_data", RAM_Data_WR, 'hAB);
        chk("load_rda", 64'(RAM_Address_RD_A), 'h11);
        tick(); IO_WR_Enable = 0; #2;
        chk("load_solver_we_blocked", 64'(RAM_WR_Enable), 0);
        tick();
        Done_Loading = 1; IO_WR_Enable = 1;
        exp_phase.push_back(2); exp_phase.push_back(3); exp_ss.push_back(cyc + 2);
        tick(); Done_Loading = 0; #2;
        chk("turn_we", 64'(RAM_WR_Enable), 0);
        tick(); #2;
        chk("solve_we", 64'(RAM_WR_Enable), 1);
        chk("solve_addr", 64'(RAM_Address_WR), 7);
        chk("solve_data", RAM_Data_WR, 'h77);
        chk("solve_rdb", 64'(RAM_Address_RD_B), 'h22);
        IO_WR_Enable = 0; Solver_WR_Enable = 0;
        ticks(9);
        Solver_Done = 1; exp_phase.push_back(0); tick(); Solver_Done = 0;
        chk("run_rv", 64'(Results_Valid), 1);
        chk("run_timeout", 64'(Timeout), 0);
        Start_Send = 1; exp_phase.push_back(4); tick(); Start_Send = 0;
        IO_WR_Enable = 1; IO_Address_RD_A = 'h15; #2;
        chk("send_we", 64'(RAM_WR_Enable), 0);
        chk("send_rda", 64'(RAM_Address_RD_A), 'h15);
        IO_WR_Enable = 0;
        tick();
        Done_Sending = 1; exp_phase.push_back(0); tick(); Done_Sending = 0;
        chk("send_rv_kept", 64'(Results_Valid), 1);
        // resend of the same results
        Start_Send = 1; exp_phase.push_back(4); tick(); Start_Send = 0;
        Done_Sending = 1; exp_phase.push_back(0); tick(); Done_Sending = 0;
        tick();

        // collision, stray starts, then watchdog expiry
        Start_Load = 1; Start_Send = 1; exp_phase.push_back(1); exp_err.push_back(cyc + 1);
        tick(); Start_Load = 0; Start_Send = 0;
        chk("collide_rv_clear", 64'(Results_Valid), 0);
        Start_Send = 1; exp_err.push_back(cyc + 1); tick(); Start_Send = 0;
        Done_Loading = 1; exp_phase.push_back(2); exp_phase.push_back(3); exp_ss.push_back(cyc + 2);
        tick(); Done_Loading = 0;
        tick();
        s = cyc;
        Start_Load = 1; exp_err.push_back(cyc + 1); tick(); Start_Load = 0;
        exp_phase.push_back(0);
        for (int i = 0; i < 100 && Phase == 3'd3; i++) tick();
        chk("wd_solve_len", 64'(cyc - s), 64'(TO));
        chk("wd_timeout", 64'(Timeout), 1);
        chk("wd_rv", 64'(Results_Valid), 0);
        Start_Send = 1; exp_err.push_back(cyc + 1); tick(); Start_Send = 0;
        tick();
        chk("send_no_results_idle", 64'(Phase), 0);

        // Solver_Done on the terminal cycle wins
        Start_Load = 1; exp_phase.push_back(1); tick(); Start_Load = 0;
        chk("load_timeout_clear", 64'(Timeout), 0);
        Done_Loading = 1; exp_phase.push_back(2); exp_phase.push_back(3); exp_ss.push_back(cyc + 2);
        tick(); Done_Loading = 0;
        tick();
        ticks(TO - 1);
        Solver_Done = 1; exp_phase.push_back(0); tick(); Solver_Done = 0;
        chk("tc_done_rv", 64'(Results_Valid), 1);
        chk("tc_done_timeout", 64'(Timeout), 0);

        // reset in the middle of a solver write
        load_to_solve();
        tick();
        Solver_WR_Enable = 1; #2;
        chk("pre_rst_we", 64'(RAM_WR_Enable), 1);
        exp_phase.push_back(0);
        RST = 0; #1;
        chk("rst_async_we", 64'(RAM_WR_Enable), 0);
        chk("rst_async_phase", 64'(Phase), 0);
        tick(); RST = 1; Solver_WR_Enable = 0;
        tick();
        chk("post_rst_phase", 64'(Phase), 0);
        chk("post_rst_rv", 64'(Results_Valid), 0);
        chk("post_rst_timeout", 64'(Timeout), 0);
        chk("post_rst_perr", 64'(Protocol_Error), 0);
        chk("post_rst_start", 64'(Solver_Start), 0);

        ticks(2);
        chk("phase_queue_drained", 64'(exp_phase.size()), 0);
        chk("err_queue_drained", 64'(exp_err.size()), 0);
        chk("start_queue_drained", 64'(exp_ss.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "bench timed out");
    end

endmodule
